// File: rtl/muldiv_if.sv
// ============================================================================
// Module      : muldiv_if
// Description : Request/response bundle between the execute stage and the
//               iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [4:0]      rd_in;
   logic            kill;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;
   logic            wr_en;

   modport master (
      output start, op, a, b, rd_in, kill,
      input  busy, done, result, rd_out, wr_en
   );

   modport slave (
      input  start, op, a, b, rd_in, kill,
      output busy, done, result, rd_out, wr_en
   );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide, fixed 33-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  wire logic clk,
   input  wire logic rst_n,
   muldiv_if.slave   bus
);
   localparam int CW = $clog2(XLEN);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   logic [1:0]        r_state;
   logic [1:0]        w_next;
   logic [CW-1:0]     r_cnt;
   logic [2:0]        r_op;
   logic [XLEN-1:0]   r_a;
   logic [XLEN-1:0]   r_b;
   logic              r_neg_a;
   logic              r_neg_b;
   logic [4:0]        r_rd;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_opnd;
   logic [XLEN-1:0]   r_result;

   logic              w_accept;
   logic              w_busy;
   logic              w_done;
   logic              w_sa;
   logic              w_sb;
   logic [XLEN-1:0]   w_mag_a;
   logic [XLEN-1:0]   w_mag_b;
   logic [XLEN:0]     w_msum;
   logic [2*XLEN-1:0] w_mul_nxt;
   logic [XLEN:0]     w_dshift;
   logic [XLEN:0]     w_ddiff;
   logic [2*XLEN-1:0] w_div_nxt;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_rem;
   logic              w_bzero;
   logic              w_ovf;
   logic [XLEN-1:0]   w_fix;

   assign w_accept = bus.start && !bus.kill && ((r_state == S_IDLE) || (r_state == S_DONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_CALC;
         S_CALC:  if (r_cnt == CW'(XLEN - 1)) w_next = S_FIX;
         S_FIX:   w_next = S_DONE;
         S_DONE:  w_next = w_accept ? S_CALC : S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (bus.kill) w_next = S_IDLE;
   end

   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_CALC:  w_busy = 1'b1;
         S_FIX:   w_busy = 1'b1;
         S_DONE:  w_done = 1'b1;
         default: ;
      endcase
   end

   // Operand signs only matter for the ops that interpret that operand as signed.
   assign w_sa    = bus.a[XLEN-1] && ((bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                                      (bus.op == OP_DIV)  || (bus.op == OP_REM));
   assign w_sb    = bus.b[XLEN-1] && ((bus.op == OP_MULH) || (bus.op == OP_DIV) ||
                                      (bus.op == OP_REM));
   assign w_mag_a = w_sa ? -bus.a : bus.a;
   assign w_mag_b = w_sb ? -bus.b : bus.b;

   // Multiply: {hi,lo} with the multiplier in lo, add-then-shift-right.
   assign w_msum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
   assign w_mul_nxt = {w_msum, r_acc[XLEN-1:1]};

   // Divide: {remainder, quotient}; the dividend shifts out of the quotient half.
   assign w_dshift  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
   assign w_ddiff   = w_dshift - {1'b0, r_opnd};
   assign w_div_nxt = w_ddiff[XLEN] ? {w_dshift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                    : {w_ddiff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};

   assign w_prod  = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
   assign w_quo   = (r_neg_a ^ r_neg_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
   assign w_rem   = r_neg_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
   assign w_bzero = (r_b == '0);
   assign w_ovf   = (r_a == {1'b1, {(XLEN-1){1'b0}}}) && (r_b == '1);

   always_comb begin
      w_fix = '0;
      case (r_op)
         OP_MUL:                      w_fix = w_prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_fix = w_prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU: begin
            if (w_bzero)                     w_fix = '1;
            else if (r_op == OP_DIV && w_ovf) w_fix = {1'b1, {(XLEN-1){1'b0}}};
            else                             w_fix = w_quo;
         end
         default: begin
            if (w_bzero)                     w_fix = r_a;
            else if (r_op == OP_REM && w_ovf) w_fix = '0;
            else                             w_fix = w_rem;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_neg_a  <= 1'b0;
         r_neg_b  <= 1'b0;
         r_rd     <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_cnt   <= '0;
         r_op    <= bus.op;
         r_a     <= bus.a;
         r_b     <= bus.b;
         r_neg_a <= w_sa;
         r_neg_b <= w_sb;
         r_rd    <= bus.rd_in;
         r_acc   <= bus.op[2] ? {{XLEN{1'b0}}, w_mag_a} : {{XLEN{1'b0}}, w_mag_b};
         r_opnd  <= bus.op[2] ? w_mag_b : w_mag_a;
      end else if (r_state == S_CALC) begin
         r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
         r_cnt <= r_cnt + 1'b1;
      end else if (r_state == S_FIX && !bus.kill) begin
         r_result <= w_fix;
      end
   end

   assign bus.busy   = w_busy;
   assign bus.done   = w_done;
   assign bus.result = r_result;
   assign bus.rd_out = r_rd;
   assign bus.wr_en  = w_done && (r_rd != 5'd0);

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed + random scoreboard bench for muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   muldiv_if #(.XLEN(32)) bus ();

   muldiv_unit #(.XLEN(32)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        wr;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] last_res = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0]        ea, eb, p;
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      ea = {{32{a[31]}}, a};
      eb = {{32{b[31]}}, b};
      case (op)
         3'b000: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
         3'b001: begin p = ea * eb; return p[63:32]; end
         3'b010: begin p = ea * {32'd0, b}; return p[63:32]; end
         3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         3'b100: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return sa / sb;
         end
         3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return sa % sb;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res, input bit push);
      exp_t e;
      if (push) begin
         e.res = exp_res;
         e.rd  = rd;
         e.wr  = (rd != 5'd0);
         sb.push_back(e);
      end
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.rd_in = rd;
      tick();
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
   endtask

   // Entered just after E0 plus 'already' further edges.
   task automatic wait_done(input string tag, input int already);
      int   n;
      int   busy_cnt;
      exp_t e;
      n        = already;
      busy_cnt = already;
      while (bus.done !== 1'b1 && n < 40) begin
         if (bus.busy === 1'b1) busy_cnt++;
         tick();
         n++;
      end
      chk({tag, "_latency"}, n, 33);
      chk({tag, "_busycyc"}, busy_cnt, 33);
      if (bus.done === 1'b1) begin
         chk({tag, "_busy_in_done"}, {31'd0, bus.busy}, 32'd0);
         if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk({tag, "_result"}, bus.result, e.res);
            chk({tag, "_rd_out"}, {27'd0, bus.rd_out}, {27'd0, e.rd});
            chk({tag, "_wr_en"}, {31'd0, bus.wr_en}, {31'd0, e.wr});
            last_res = e.res;
         end
      end
   endtask

   task automatic settle(input string tag);
      tick();
      chk({tag, "_done_fall"}, {31'd0, bus.done}, 32'd0);
      chk({tag, "_wr_fall"}, {31'd0, bus.wr_en}, 32'd0);
      chk({tag, "_res_hold"}, bus.result, last_res);
   endtask

   task automatic check_quiet(input string tag, input int cycles);
      int pulses;
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         if (bus.done === 1'b1) pulses++;
         tick();
      end
      chk({tag, "_no_done"}, pulses, 0);
   endtask

   task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res);
      issue(op, a, b, rd, exp_res, 1'b1);
      wait_done(tag, 0);
      settle(tag);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.kill  = 1'b0;
      bus.op    = '0;
      bus.a     = '0;
      bus.b     = '0;
      bus.rd_in = '0;
      repeat (3) tick();
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_wr", {31'd0, bus.wr_en}, 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_rd", {27'd0, bus.rd_out}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Reset in the middle of an operation
      issue(3'b000, 32'd9, 32'd9, 5'd3, 32'd0, 1'b0);
      repeat (9) tick();
      chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst_done", {31'd0, bus.done}, 32'd0);
      tick();
      rst_n = 1'b1;
      check_quiet("midrst", 40);
      chk("midrst_result", bus.result, 32'd0);

      run("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
      run("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000);
      run("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE);
      run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF);
      run("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD);
      run("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF);
      run("divu", 3'b101, 32'd100, 32'd7, 5'd11, 32'd14);
      run("remu", 3'b111, 32'd100, 32'd7, 5'd12, 32'd2);
      run("divu0", 3'b101, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF);
      run("remu0", 3'b111, 32'd5, 32'd0, 5'd14, 32'd5);
      run("div0", 3'b100, 32'hFFFF_FFFB, 32'd0, 5'd15, 32'hFFFF_FFFF);
      run("rem0", 3'b110, 32'hFFFF_FFFB, 32'd0, 5'd16, 32'hFFFF_FFFB);
      run("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000);
      run("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0);
      run("rd0", 3'b000, 32'd3, 32'd4, 5'd0, 32'd12);

      for (int i = 0; i < 10; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = (i == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
         run($sformatf("rnd%0d", i), op, a, b, 5'($urandom_range(1, 31)), model(op, a, b));
      end

      // Start while busy is dropped
      issue(3'b101, 32'd1000, 32'd10, 5'd20, 32'd100, 1'b1);
      repeat (9) tick();
      bus.start = 1'b1;
      bus.op    = 3'b000;
      bus.a     = 32'd3;
      bus.b     = 32'd3;
      bus.rd_in = 5'd21;
      tick();
      bus.start = 1'b0;
      wait_done("ignbusy", 10);
      settle("ignbusy");
      check_quiet("ignbusy", 40);

      // Kill at iteration 20
      issue(3'b000, 32'd5, 32'd6, 5'd22, 32'd0, 1'b0);
      repeat (20) tick();
      bus.kill = 1'b1;
      tick();
      bus.kill = 1'b0;
      chk("kill_busy", {31'd0, bus.busy}, 32'd0);
      check_quiet("kill", 40);
      chk("kill_result", bus.result, last_res);

      // Kill and start together
      bus.kill = 1'b1;
      issue(3'b000, 32'd5, 32'd6, 5'd23, 32'd0, 1'b0);
      bus.kill = 1'b0;
      chk("killstart_busy", {31'd0, bus.busy}, 32'd0);
      check_quiet("killstart", 40);

      // Back-to-back: second start accepted in the DONE cycle
      issue(3'b100, 32'd50, 32'hFFFF_FFFB, 5'd24, 32'hFFFF_FFF6, 1'b1);
      wait_done("b2b_first", 0);
      issue(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd25,
            model(3'b011, 32'h1234_5678, 32'h9ABC_DEF0), 1'b1);
      wait_done("b2b_second", 0);
      settle("b2b");

      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
